// File: rtl/register_dump_reader.sv
// Streams a contiguous (wrapping) range of register-file Q buses out over valid/ready.
// Each word is snapshotted from q_flat when it is loaded into the output register.
module register_dump_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start,
   input  logic                                   abort,
   input  logic [ADDR_WIDTH-1:0]                  first_addr,
   input  logic [ADDR_WIDTH-1:0]                  last_addr,
   input  logic [DATA_WIDTH*(2**ADDR_WIDTH)-1:0]  q_flat,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [DATA_WIDTH-1:0]                  out_data,
   output logic [ADDR_WIDTH-1:0]                  out_addr,
   output logic                                   out_last,
   output logic                                   busy,
   output logic                                   done
);

   localparam int unsigned NREGS = 2**ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   last_r;
   logic [ADDR_WIDTH-1:0]   next_addr;
   logic [DATA_WIDTH-1:0]   words [NREGS];

   always_comb begin
      for (int unsigned i = 0; i < NREGS; i++) begin
         words[i] = q_flat[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign next_addr = out_addr + ADDR_WIDTH'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         last_r    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_addr  <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  last_r    <= last_addr;
                  out_addr  <= first_addr;
                  out_data  <= words[first_addr];
                  out_last  <= (first_addr == last_addr);
                  out_valid <= 1'b1;
                  busy      <= 1'b1;
                  state     <= SEND;
               end
            end
            SEND: begin
               // abort wins over a transfer presented on the same edge
               if (abort) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else if (out_valid && out_ready) begin
                  if (out_last) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     done      <= 1'b1;
                     state     <= DONE;
                  end else begin
                     out_addr <= next_addr;
                     out_data <= words[next_addr];
                     out_last <= (next_addr == last_r);
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_register_dump_reader.sv
// Scoreboard bench: dump requests push expected words; a negedge monitor checks every transfer.
module tb_register_dump_reader;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              start, abort, out_ready;
   logic [AW-1:0]     first_addr, last_addr;
   logic [DW*NR-1:0]  q_flat;
   logic              out_valid, out_last, busy, done;
   logic [DW-1:0]     out_data;
   logic [AW-1:0]     out_addr;

   logic [DW-1:0]     q [NR];
   logic [DW+AW:0]    sb [$];
   int                total = 0;
   int                errs = 0;
   int                xfers = 0;
   int                done_cnt = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NR; g++) begin : g_flat
      assign q_flat[g*DW +: DW] = q[g];
   end

   register_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .first_addr(first_addr), .last_addr(last_addr), .q_flat(q_flat),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (done) done_cnt++;
         if (out_valid && out_ready && !abort) begin
            xfers++;
            if (sb.size() == 0) begin
               total++;
               errs++;
               $display("FAIL unexpected_word: got addr %0d data %0h, expected none", out_addr, out_data);
            end else begin
               chk("word", {out_data, out_addr, out_last}, sb.pop_front());
            end
         end
      end
   end

   task automatic push_range(input logic [AW-1:0] f, input logic [AW-1:0] l, output int n);
      logic [AW-1:0] a;
      n = int'(AW'(l - f)) + 1;
      for (int i = 0; i < n; i++) begin
         a = AW'(int'(f) + i);
         sb.push_back({q[a], a, (i == n - 1)});
      end
   endtask

   // mode 0: ready held high; 1: random ready + ignored starts; 2: ready pattern 1,0,0,1,1 with Q3 rewrite
   task automatic run_dump(input logic [AW-1:0] f, input logic [AW-1:0] l, input int mode);
      int n, cyc, x0;
      bit fin;
      logic [4:0] pat;
      pat = 5'b11001;
      push_range(f, l, n);
      x0 = xfers;
      first_addr = f;
      last_addr  = l;
      start      = 1'b1;
      out_ready  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      first_addr = AW'($urandom);
      last_addr  = AW'($urandom);
      chk("latency", {out_valid, out_addr, busy}, {1'b1, f, 1'b1});
      cyc = 0;
      fin = 1'b0;
      while (!fin && cyc < 2000) begin
         case (mode)
            1: begin
               out_ready  = ($urandom_range(0, 3) != 0);
               start      = ($urandom_range(0, 7) == 0);
               first_addr = AW'($urandom);
               last_addr  = AW'($urandom);
            end
            2: begin
               out_ready = (cyc < 5) ? pat[cyc] : 1'b1;
               if (cyc == 1) q[3] = 32'hDEAD_BEEF;
            end
            default: out_ready = 1'b1;
         endcase
         @(posedge clk); #1;
         cyc++;
         if (done) fin = 1'b1;
      end
      start = 1'b0;
      out_ready = 1'b1;
      if (!fin) begin
         total++;
         errs++;
         $display("FAIL done_timeout: got no done after %0d cycles, expected done", cyc);
         rst = 1'b1; #1; rst = 1'b0;
         sb.delete();
      end else begin
         if (mode == 0) chk("cycles", cyc, n);
         chk("transfers", xfers - x0, n);
         chk("done_state", {done, busy, out_valid}, 3'b110);
         @(posedge clk); #1;
         chk("idle_after", {done, busy, out_valid}, 3'b000);
         chk("sb_empty", sb.size(), 0);
      end
   endtask

   initial begin
      int n, dc;
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      out_ready = 1'b0;
      first_addr = '0;
      last_addr = '0;
      for (int i = 0; i < NR; i++) q[i] = 32'(i * 32'h1111_1111);
      repeat (2) @(posedge clk);
      #1;
      chk("reset", {out_valid, out_data, out_addr, out_last, busy, done}, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_dump(5'd0, 5'd31, 0);
      run_dump(5'd5, 5'd5, 0);
      run_dump(5'd30, 5'd1, 0);
      run_dump(5'd2, 5'd4, 2);
      q[3] = 32'h3333_3333;

      // abort on the second word of 0..9
      dc = done_cnt;
      push_range(5'd0, 5'd9, n);
      first_addr = 5'd0;
      last_addr  = 5'd9;
      start = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      chk("abort_word", {out_valid, out_addr}, {1'b1, 5'd1});
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort_out", {out_valid, busy, done}, 3'b000);
      chk("abort_remaining", sb.size(), 9);
      sb.delete();
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt, dc);
      run_dump(5'd3, 5'd7, 0);

      // asynchronous reset mid-dump
      push_range(5'd0, 5'd31, n);
      first_addr = 5'd0;
      last_addr  = 5'd31;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_mid", {out_valid, out_data, out_addr, out_last, busy, done}, 0);
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_idle", {out_valid, busy}, 2'b00);

      for (int t = 0; t < 24; t++) begin
         for (int i = 0; i < NR; i++) q[i] = $urandom;
         run_dump(AW'($urandom), AW'($urandom), (t % 3 == 0) ? 0 : 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", total, errs);
      $finish;
   end

endmodule
